// File: rtl/enc_pkg.sv
// Shared definitions for the request capture front end and the downstream
// index encoders: index-width helper and lowest-index-wins priority search.
package enc_pkg;

  localparam int MAX_N = 32;
  localparam int MAX_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] idx;
    logic             found;
  } sel_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Scans from the top so the last hit, i.e. the lowest index, wins.
  function automatic sel_t lowest_set_index(input logic [MAX_N-1:0] vec);
    sel_t r;
    r = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.idx   = MAX_W'(i);
        r.found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/req_capture_encoder_if.sv
// Valid/ready index stream leaving the request capture block.
interface req_capture_encoder_if
  import enc_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = clog2_min1(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);

endinterface

// File: rtl/lsb_index_find.sv
// Combinational lowest-set-bit finder; index 0 has highest priority.
module lsb_index_find
  import enc_pkg::*;
#(
  parameter int  N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  sel_t sel;

  // Zero-extension keeps indices >= N from ever being reported.
  assign sel   = lowest_set_index(MAX_N'(vec));
  assign idx   = W'(sel.idx);
  assign found = sel.found;

endmodule

// File: rtl/req_capture_encoder.sv
// Sticky request capture with lowest-index selection onto a registered
// valid/ready index stream; the served bit is cleared on acceptance.
module req_capture_encoder
  import enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0]                  req_i,
  input  logic [N-1:0]                  mask_i,
  input  logic                          clear_i,
  req_capture_encoder_if.master         out_if,
  output logic [N-1:0]                  pending_o,
  output logic                          overflow_o
);

  localparam int W = clog2_min1(N);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;

  logic         acc;
  logic [N-1:0] idx_onehot;
  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [W-1:0] sel_idx;
  logic         sel_found;

  lsb_index_find #(.N(N)) u_find (
    .vec   (eligible),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    idx_onehot         = '0;
    idx_onehot[idx_q]  = 1'b1;
    acc                = (state_q == ST_HOLD) && out_if.out_ready;
    clr                = acc ? idx_onehot : '0;
    // The held index is never re-offered while it is still on the bus.
    eligible           = pending_q & ~mask_i & ~((state_q == ST_HOLD) ? idx_onehot : '0);

    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = (pending_q & ~clr) | req_i;
    overflow_d = overflow_q | (|(req_i & pending_q & ~clr));

    if (clear_i) begin
      state_d    = ST_IDLE;
      pending_d  = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            state_d = ST_HOLD;
            idx_d   = sel_idx;
          end
        end
        ST_HOLD: begin
          if (acc) begin
            if (sel_found) idx_d   = sel_idx;
            else           state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_if.out_valid = (state_q == ST_HOLD);
  assign out_if.out_idx   = idx_q;
  assign pending_o        = pending_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a behavioural model.
module tb_req_capture_encoder;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic [N-1:0] mask_i;
  logic         clear_i;
  logic [N-1:0] pending_o;
  logic         overflow_o;

  req_capture_encoder_if #(.N(N)) out_if ();

  req_capture_encoder #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .clear_i    (clear_i),
    .out_if     (out_if),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       clr;
    logic       rdy;
    logic       ev;
    logic [2:0] eidx;
    logic [7:0] ep;
    logic       eovf;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  bit [7:0] m_pend;
  bit       m_valid;
  int       m_idx;
  bit       m_ovf;

  function automatic vec_t mk(input logic [7:0] req, mask, input logic clr, rdy,
                              input logic ev, input logic [2:0] eidx,
                              input logic [7:0] ep, input logic eovf);
    vec_t v;
    v.req = req; v.mask = mask; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.eidx = eidx; v.ep = ep; v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, check on the falling edge.
  task automatic cyc(input string tag, input logic [7:0] req, mask, input logic clr, rdy,
                     input logic ev, input logic [2:0] eidx,
                     input logic [7:0] ep, input logic eovf);
    req_i            = req;
    mask_i           = mask;
    clear_i          = clr;
    out_if.out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid"},    32'(out_if.out_valid), 32'(ev));
    check({tag, ".idx"},      32'(out_if.out_idx),   32'(eidx));
    check({tag, ".pending"},  32'(pending_o),        32'(ep));
    check({tag, ".overflow"}, 32'(overflow_o),       32'(eovf));
    req_i   = '0;
    clear_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},    32'(out_if.out_valid), 32'd0);
    check({tag, ".idx"},      32'(out_if.out_idx),   32'd0);
    check({tag, ".pending"},  32'(pending_o),        32'd0);
    check({tag, ".overflow"}, 32'(overflow_o),       32'd0);
  endtask

  // Spec-level model: sticky set of pending requests, one served index at a time.
  task automatic model_step(input logic [7:0] req, mask, input logic clr, rdy);
    bit       acc;
    bit       served;
    int       pick;
    bit [7:0] np;
    bit       novf;
    acc  = m_valid && rdy;
    pick = -1;
    np   = m_pend;
    novf = m_ovf;
    if (clr) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (pick < 0 && m_pend[k] && !mask[k] && !(m_valid && k == m_idx)) pick = k;
    end
    for (int k = 0; k < N; k++) begin
      served = acc && (k == m_idx);
      if (req[k] && m_pend[k] && !served) novf = 1'b1;
      np[k] = (m_pend[k] && !served) || req[k];
    end
    if (!m_valid || acc) begin
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_idx   = pick;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_pend = np;
    m_ovf  = novf;
  endtask

  initial begin
    logic [7:0] r_req, r_mask;
    logic       r_clr, r_rdy;

    // Single request
    tbl.push_back(mk(8'h20, 8'h00, 0, 1, 0, 3'd0, 8'h20, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 1, 3'd5, 8'h20, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 3'd5, 8'h00, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 3'd5, 8'h00, 0));
    // Burst: 0, 4, 7 back-to-back
    tbl.push_back(mk(8'h91, 8'h00, 0, 1, 0, 3'd5, 8'h91, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 1, 3'd0, 8'h91, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 1, 3'd4, 8'h90, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 1, 3'd7, 8'h80, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 3'd7, 8'h00, 0));
    // Mask excludes index 0 until lifted
    tbl.push_back(mk(8'h03, 8'h01, 0, 1, 0, 3'd7, 8'h03, 0));
    tbl.push_back(mk(8'h00, 8'h01, 0, 1, 1, 3'd1, 8'h03, 0));
    tbl.push_back(mk(8'h00, 8'h01, 0, 1, 0, 3'd1, 8'h01, 0));
    tbl.push_back(mk(8'h00, 8'h01, 0, 1, 0, 3'd1, 8'h01, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 1, 3'd0, 8'h01, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0));
    // Overflow on a repeated request, then flush
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 0, 3'd0, 8'h04, 0));
    tbl.push_back(mk(8'h04, 8'h00, 0, 0, 1, 3'd2, 8'h04, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 3'd2, 8'h04, 1));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 0, 3'd2, 8'h00, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 3'd2, 8'h00, 0));

    rst_n            = 1'b0;
    req_i            = '0;
    mask_i           = '0;
    clear_i          = 1'b0;
    out_if.out_ready = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc($sformatf("vec%0d", i), tbl[i].req, tbl[i].mask, tbl[i].clr, tbl[i].rdy,
          tbl[i].ev, tbl[i].eidx, tbl[i].ep, tbl[i].eovf);
    end

    // Backpressure: held index stays put, then drains 3 then 1
    cyc("bp0", 8'h08, 8'h00, 0, 0, 0, 3'd2, 8'h08, 0);
    cyc("bp1", 8'h00, 8'h00, 0, 0, 1, 3'd3, 8'h08, 0);
    cyc("bp2", 8'h00, 8'h00, 0, 0, 1, 3'd3, 8'h08, 0);
    cyc("bp3", 8'h02, 8'h00, 0, 0, 1, 3'd3, 8'h0A, 0);
    cyc("bp4", 8'h00, 8'h00, 0, 0, 1, 3'd3, 8'h0A, 0);
    cyc("bp5", 8'h00, 8'h00, 0, 1, 1, 3'd1, 8'h02, 0);
    cyc("bp6", 8'h00, 8'h00, 0, 1, 0, 3'd1, 8'h00, 0);

    // Asynchronous reset while holding index 4
    cyc("rh0", 8'h10, 8'h00, 0, 0, 0, 3'd1, 8'h10, 0);
    cyc("rh1", 8'h00, 8'h00, 0, 0, 1, 3'd4, 8'h10, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Re-pend on the accepted index; no overflow for that bit
    cyc("rp0", 8'h40, 8'h00, 0, 0, 0, 3'd0, 8'h40, 0);
    cyc("rp1", 8'h00, 8'h00, 0, 0, 1, 3'd6, 8'h40, 0);
    cyc("rp2", 8'h40, 8'h00, 0, 1, 0, 3'd6, 8'h40, 0);
    cyc("rp3", 8'h00, 8'h00, 0, 1, 1, 3'd6, 8'h40, 0);
    cyc("rp4", 8'h00, 8'h00, 0, 1, 0, 3'd6, 8'h00, 0);

    // Random traffic against the model, from a fresh reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ovf   = 1'b0;
    for (int t = 0; t < 400; t++) begin
      r_req  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      r_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      r_clr  = ($urandom_range(0, 39) == 0);
      r_rdy  = ($urandom_range(0, 9) < 7);
      model_step(r_req, r_mask, r_clr, r_rdy);
      cyc($sformatf("rnd%0d", t), r_req, r_mask, r_clr, r_rdy,
          m_valid, 3'(m_idx), m_pend, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
